gshare_predictor: RTL and testbench
===================================

// Module: gshare_predictor
// PURPOSE
//  Parametrised direction predictor for the fetch stage: 2^IDX_BITS saturating counters
//  indexed by PC bits XOR a global history register (GHR); HIST_BITS=0 gives plain bimodal.
//  Predicts in IF, is updated from EX with the resolved outcome; auto-initialises after reset/clear.
// PARAMETERS
//  IDX_BITS   5  table index width; entries = 2^IDX_BITS
//  CTR_BITS   2  counter width (>=1); predict taken when counter MSB = 1
//  HIST_BITS  5  GHR width (0..IDX_BITS); GHR XORed into low HIST_BITS of index
// PORTS
//  clk         in   1          clock
//  arst_n      in   1          async reset, active-low
//  clr         in   1          sync soft clear: restart table init, zero GHR
//  rd_valid    in   1          predict request this cycle
//  rd_pc       in   IDX_BITS   PC index bits (word address)
//  pred_valid  out  1          pred_taken/pred_ghr valid (1 cycle after rd_valid)
//  pred_taken  out  1          predicted direction
//  pred_ghr    out  max(HIST_BITS,1)  GHR snapshot used for this prediction
//  upd_valid   in   1          resolved-branch update
//  upd_pc      in   IDX_BITS   PC index bits of resolved branch
//  upd_ghr     in   max(HIST_BITS,1)  pred_ghr carried with that branch
//  upd_taken   in   1          actual outcome
//  ready       out  1          0 during init sweep
// BEHAVIOUR
//  Reset: arst_n low -> state INIT, init_ptr=0, GHR=0, pred_valid=0, pred_taken=0,
//   pred_ghr=0, ready=0. Table contents undefined until swept.
//  FSM: INIT -> writes counter[init_ptr] = WNT (2^(CTR_BITS-1)-1; CTR_BITS=1 -> 0),
//   init_ptr++ each cycle; after entry 2^IDX_BITS-1 -> READY (sweep = 2^IDX_BITS cycles).
//   READY -> INIT on clr (init_ptr=0, GHR=0). clr in INIT restarts the sweep.
//  In INIT: rd_valid yields pred_valid=1, pred_taken=0, pred_ghr=0; upd_valid ignored
//   (no table or GHR change).
//  Predict (READY): ridx = rd_pc ^ {0, GHR}; next cycle pred_valid=1,
//   pred_taken = MSB(counter[ridx]), pred_ghr = GHR at request. pred_valid=0 otherwise
//   (pred_taken/pred_ghr hold).
//  Update (READY, upd_valid): widx = upd_pc ^ {0, upd_ghr};
//   taken: counter = min(counter+1, 2^CTR_BITS-1); not taken: counter = max(counter-1, 0).
//   Counter written at clock edge; GHR <= {GHR[HIST_BITS-2:0], upd_taken} same edge.
//  Same-cycle rd and upd with ridx==widx: prediction uses post-update counter (bypass).
//   ridx is computed from GHR before the same-cycle shift.
//  HIST_BITS=0: GHR absent, index = PC only, pred_ghr=0, upd_ghr ignored.
//  Index arithmetic mod 2^IDX_BITS; no out-of-range entry exists.
//  Reset asserted mid-sweep or mid-operation: immediate return to reset state; sweep restarts.
// TESTING
//  1 Reset, count cycles to ready=1 -> exactly 32 (defaults); pred_taken=0 for all 32 idx.
//  2 HIST_BITS=0, upd pc=3 taken x3 -> counter 01,10,11; pred pc=3 =1; 2 not-taken -> 10,01, pred 0.
//  3 Saturation: 5 taken updates at idx 7 then 1 not-taken -> counter 10, pred still 1;
//    5 not-taken at idx 8 -> stays 00.
//  4 Defaults, outcomes T,T,N -> GHR=5'b00110; rd_pc=5'b00011 indexes 5, pred_ghr=5'b00110.
//  5 Same-cycle rd/upd both idx 4, counter 01, upd taken -> pred_taken=1 next cycle.
//  6 clr in READY -> ready=0 32 cycles, updates during sweep dropped, all counters 01 after.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: a table of saturating counters indexed by PC XOR global history.
// The table sweeps itself to weakly-not-taken after reset or clr before serving predictions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | sweeping table to WNT, predictions forced not-taken, updates dropped
// ST_READY | table valid, predictions served, resolved branches train table and GHR
module gshare_predictor #(
    parameter int IDX_BITS  = 5,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 5,
    localparam int GHR_W    = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                clr,
    input  logic                rd_valid,
    input  logic [IDX_BITS-1:0] rd_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [GHR_W-1:0]    pred_ghr,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_pc,
    input  logic [GHR_W-1:0]    upd_ghr,
    input  logic                upd_taken,
    output logic                ready
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [IDX_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [GHR_W-1:0]    ghr_q, ghr_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [GHR_W-1:0]    pred_ghr_q, pred_ghr_d;
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];

    logic [IDX_BITS-1:0] ridx, widx;
    logic [CTR_BITS-1:0] upd_old, upd_new, rd_ctr;
    logic                upd_en;

    always_comb begin
        ridx    = rd_pc;
        widx    = upd_pc;
        if (HIST_BITS > 0) begin
            ridx = rd_pc ^ IDX_BITS'(ghr_q);
            widx = upd_pc ^ IDX_BITS'(upd_ghr);
        end
        upd_en  = (state_q == ST_READY) && upd_valid && !clr;
        upd_old = ctr_q[widx];
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != CTR_MAX) upd_new = upd_old + CTR_BITS'(1);
        end else begin
            if (upd_old != '0) upd_new = upd_old - CTR_BITS'(1);
        end
        // Same-cycle update to the entry being read is forwarded to the prediction.
        rd_ctr = (upd_en && (ridx == widx)) ? upd_new : ctr_q[ridx];
    end

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ghr_d        = ghr_q;
        ctr_d        = ctr_q;
        pred_valid_d = rd_valid;
        pred_taken_d = pred_taken_q;
        pred_ghr_d   = pred_ghr_q;

        case (state_q)
            ST_INIT: begin
                ctr_d[init_ptr_q] = CTR_WNT;
                init_ptr_d        = init_ptr_q + IDX_BITS'(1);
                if (init_ptr_q == PTR_LAST) state_d = ST_READY;
                if (rd_valid) begin
                    pred_taken_d = 1'b0;
                    pred_ghr_d   = '0;
                end
            end
            ST_READY: begin
                if (rd_valid) begin
                    pred_taken_d = (rd_ctr > CTR_WNT);
                    pred_ghr_d   = ghr_q;
                end
                if (upd_en) begin
                    ctr_d[widx] = upd_new;
                    if (HIST_BITS > 0) ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (clr) begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
            ghr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    // Table has no reset; the init sweep gives every entry a defined value.
    always_ff @(posedge clk) begin
        ctr_q <= ctr_d;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_ghr   = pred_ghr_q;
    assign ready      = (state_q == ST_READY);

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: default instance checked against a table-level reference model,
// plus a bimodal (HIST_BITS=0) instance driven from a vector table.
module tb_gshare_predictor;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       arst_n;
    always #5 clk = ~clk;

    logic       a_clr, a_rd_valid, a_pred_valid, a_pred_taken;
    logic       a_upd_valid, a_upd_taken, a_ready;
    logic [4:0] a_rd_pc, a_pred_ghr, a_upd_pc, a_upd_ghr;

    logic       b_clr, b_rd_valid, b_pred_valid, b_pred_taken;
    logic       b_upd_valid, b_upd_taken, b_ready;
    logic [4:0] b_rd_pc, b_upd_pc;
    logic [0:0] b_pred_ghr, b_upd_ghr;

    gshare_predictor dut_a (
        .clk(clk), .arst_n(arst_n), .clr(a_clr),
        .rd_valid(a_rd_valid), .rd_pc(a_rd_pc),
        .pred_valid(a_pred_valid), .pred_taken(a_pred_taken), .pred_ghr(a_pred_ghr),
        .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_ghr(a_upd_ghr),
        .upd_taken(a_upd_taken), .ready(a_ready)
    );

    gshare_predictor #(.IDX_BITS(5), .CTR_BITS(2), .HIST_BITS(0)) dut_b (
        .clk(clk), .arst_n(arst_n), .clr(b_clr),
        .rd_valid(b_rd_valid), .rd_pc(b_rd_pc),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_ghr(b_pred_ghr),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_ghr(b_upd_ghr),
        .upd_taken(b_upd_taken), .ready(b_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counter values as integers, history as an integer, sweep as a countdown.
    int m_ctr [N];
    int m_ghr;
    int m_init_left;
    int m_pt;
    int m_pg;

    task automatic do_reset();
        arst_n = 1'b0;
        #2;
        chk("rst_ready", int'(a_ready), 0);
        chk("rst_pred_valid", int'(a_pred_valid), 0);
        chk("rst_pred_taken", int'(a_pred_taken), 0);
        chk("rst_pred_ghr", int'(a_pred_ghr), 0);
        m_ghr = 0;
        m_init_left = N;
        m_pt = 0;
        m_pg = 0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic cyc_a(input bit rdv, input int rpc, input bit uv, input int upc,
                         input int ughr, input bit ut, input bit cl);
        int ridx, widx, c_new;
        a_rd_valid  = rdv;
        a_rd_pc     = 5'(rpc);
        a_upd_valid = uv;
        a_upd_pc    = 5'(upc);
        a_upd_ghr   = 5'(ughr);
        a_upd_taken = ut;
        a_clr       = cl;
        if (m_init_left == 0) begin
            ridx  = (rpc ^ m_ghr) % N;
            widx  = (upc ^ ughr) % N;
            c_new = ut ? ((m_ctr[widx] < 3) ? m_ctr[widx] + 1 : 3)
                       : ((m_ctr[widx] > 0) ? m_ctr[widx] - 1 : 0);
            if (rdv) begin
                if (uv && !cl && ridx == widx) m_pt = (c_new >= 2) ? 1 : 0;
                else m_pt = (m_ctr[ridx] >= 2) ? 1 : 0;
                m_pg = m_ghr;
            end
            if (uv && !cl) begin
                m_ctr[widx] = c_new;
                m_ghr = ((m_ghr << 1) | int'(ut)) % N;
            end
            if (cl) begin
                m_init_left = N;
                m_ghr = 0;
            end
        end else begin
            if (rdv) begin
                m_pt = 0;
                m_pg = 0;
            end
            if (cl) begin
                m_init_left = N;
                m_ghr = 0;
            end else begin
                m_init_left--;
                if (m_init_left == 0) foreach (m_ctr[i]) m_ctr[i] = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid", int'(a_pred_valid), int'(rdv));
        chk("pred_taken", int'(a_pred_taken), m_pt);
        chk("pred_ghr", int'(a_pred_ghr), m_pg);
        chk("ready", int'(a_ready), (m_init_left == 0) ? 1 : 0);
    endtask

    typedef struct {
        bit uv;
        int upc;
        bit ut;
        bit rdv;
        int rpc;
        bit exp_taken;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit uv, int upc, bit ut, bit rdv, int rpc, bit et);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.rdv = rdv; v.rpc = rpc; v.exp_taken = et;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        int rpc, upc, ughr;
        bit rdv, uv;

        a_clr = 0; a_rd_valid = 0; a_rd_pc = 0; a_upd_valid = 0; a_upd_pc = 0;
        a_upd_ghr = 0; a_upd_taken = 0;
        b_clr = 0; b_rd_valid = 0; b_rd_pc = 0; b_upd_valid = 0; b_upd_pc = 0;
        b_upd_ghr = 0; b_upd_taken = 0;

        // Reset, sweep length with random reads during the sweep (always not-taken).
        do_reset();
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 100) begin
            cyc_a(1'($urandom % 2), int'($urandom % N), 1'b1, int'($urandom % N),
                  int'($urandom % N), 1'b1, 1'b0);
            cnt++;
        end
        chk("sweep_cycles_after_reset", cnt, 32);
        for (int i = 0; i < N; i++) cyc_a(1'b1, i, 1'b0, 0, 0, 1'b0, 1'b0);

        // Reset asserted mid-sweep restarts the full sweep.
        cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        do_reset();
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 100) begin
            cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
            cnt++;
        end
        chk("sweep_cycles_after_midsweep_reset", cnt, 32);

        // History: T,T,N gives GHR 00110; rd_pc 3 then indexes entry 5 (trained to 11).
        cyc_a(1'b0, 0, 1'b1, 5, 0, 1'b1, 1'b0);
        cyc_a(1'b0, 0, 1'b1, 5, 0, 1'b1, 1'b0);
        cyc_a(1'b0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
        cyc_a(1'b1, 3, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("ghr_snapshot_00110", int'(a_pred_ghr), 6);
        chk("ghr_index_entry5_taken", int'(a_pred_taken), 1);

        // Fresh table, then same-cycle read/update of entry 4 (bypass).
        cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 100) begin
            cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
            cnt++;
        end
        cyc_a(1'b1, 4, 1'b1, 4, 0, 1'b1, 1'b0);
        chk("bypass_same_cycle_taken", int'(a_pred_taken), 1);
        cyc_a(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("bypass_followup_ghr", int'(a_pred_ghr), 1);
        chk("bypass_followup_taken", int'(a_pred_taken), 1);

        // clr in READY: 32 not-ready cycles, updates dropped, table back to 01, GHR zero.
        cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 100) begin
            cyc_a(1'b1, int'($urandom % N), 1'b1, int'($urandom % N), int'($urandom % N),
                  1'b1, 1'b0);
            cnt++;
        end
        chk("sweep_cycles_after_clr", cnt, 32);
        for (int i = 0; i < N; i++) begin
            cyc_a(1'b1, i, 1'b0, 0, 0, 1'b0, 1'b0);
            chk("post_clr_ghr_zero", int'(a_pred_ghr), 0);
        end
        cyc_a(1'b1, 9, 1'b1, 9, 0, 1'b1, 1'b0);
        chk("post_clr_entry_is_wnt", int'(a_pred_taken), 1);

        // Randomised traffic against the model, with occasional clears and aliased indices.
        for (int k = 0; k < 2000; k++) begin
            rdv  = 1'($urandom % 2);
            uv   = 1'($urandom % 2);
            rpc  = int'($urandom % N);
            ughr = int'($urandom % N);
            upc  = ($urandom % 4 == 0) ? ((rpc ^ m_ghr ^ ughr) % N) : int'($urandom % N);
            if ($urandom % 300 == 0) cyc_a(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
            else cyc_a(rdv, rpc, uv, upc, ughr, 1'($urandom % 2), 1'b0);
        end
        a_rd_valid = 0; a_upd_valid = 0; a_clr = 0;

        // Bimodal instance: entries start at 01; each row reads with same-cycle bypass.
        chk("bimodal_ready", int'(b_ready), 1);
        tbl.push_back(mk(0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(1, 3, 1, 1, 3, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 3, 1));
        tbl.push_back(mk(1, 3, 0, 1, 3, 1));
        tbl.push_back(mk(1, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 7, 1, 1, 7, 1));
        tbl.push_back(mk(1, 7, 0, 1, 7, 1));
        tbl.push_back(mk(1, 7, 0, 1, 7, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 8, 0, 1, 8, 0));
        tbl.push_back(mk(1, 8, 1, 1, 8, 0));
        tbl.push_back(mk(1, 8, 1, 1, 8, 1));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8, 1));

        foreach (tbl[i]) begin
            b_upd_valid = tbl[i].uv;
            b_upd_pc    = 5'(tbl[i].upc);
            b_upd_taken = tbl[i].ut;
            b_upd_ghr   = 1'($urandom % 2);
            b_rd_valid  = tbl[i].rdv;
            b_rd_pc     = 5'(tbl[i].rpc);
            @(posedge clk);
            #1;
            chk("bimodal_pred_valid", int'(b_pred_valid), int'(tbl[i].rdv));
            if (tbl[i].rdv) begin
                chk("bimodal_pred_taken", int'(b_pred_taken), int'(tbl[i].exp_taken));
                chk("bimodal_pred_ghr", int'(b_pred_ghr), 0);
            end
        end
        b_rd_valid = 0; b_upd_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
